// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// Holds the FSM state encoding and channel/select dimensions.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last channel of a scan; its sample completes the word.
    function automatic logic is_last_ch(input logic [SEL_W-1:0] ch);
        return (ch == SEL_W'(NUM_CH - 1));
    endfunction

    // Merge one sampled bit into the partial scan word at position ch.
    function automatic logic [NUM_CH-1:0] merge_bit(
        input logic [NUM_CH-1:0] word,
        input logic [SEL_W-1:0]  ch,
        input logic              bit_in
    );
        logic [NUM_CH-1:0] mask;
        mask = NUM_CH'(1) << ch;
        return bit_in ? (word | mask) : (word & ~mask);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle counter for the scan controller: counts while enabled, and flags
// terminal count when the current select value has been held long enough.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_r;

    assign tc = (cnt_r == CNT_W'(SETTLE_CYCLES - 1));

    // Counter wraps to zero at terminal count so the next channel starts fresh.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (tc) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 4:1 select mux: walks channels 0..3, samples the
// mux after a settle period, and hands the 4-bit word out via valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       cont_i,
    input  logic       mux_out_i,
    output logic       sel0_o,
    output logic       sel1_o,
    output logic       busy_o,
    output logic [3:0] data_o,
    output logic       valid_o,
    input  logic       ready_i
);

    state_t             state_r;
    logic [SEL_W-1:0]   ch_r;
    logic [NUM_CH-1:0]  work_r;
    logic [NUM_CH-1:0]  data_r;
    logic               valid_r;
    logic               busy_r;
    logic               tc_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic [NUM_CH-1:0]  capture_s;

    // The timer only runs in SETTLE; anywhere else it is held at zero so a
    // fresh scan always starts with a full settle period.
    assign timer_en_s  = (state_r == SETTLE);
    assign timer_clr_s = (state_r != SETTLE);
    assign capture_s   = merge_bit(work_r, ch_r, mux_out_i);

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (timer_clr_s),
        .en     (timer_en_s),
        .tc     (tc_s)
    );

    // Scan FSM with channel index, partial word and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            ch_r    <= '0;
            work_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ch_r <= '0;
                    if (start_i) begin
                        state_r <= SETTLE;
                        work_r  <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (tc_s) begin
                        work_r <= capture_s;
                        if (is_last_ch(ch_r)) begin
                            // data_o only ever sees a completed word.
                            data_r  <= capture_s;
                            valid_r <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            ch_r <= ch_r + SEL_W'(1);
                        end
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        ch_r    <= '0;
                        if (cont_i) begin
                            state_r <= SETTLE;
                            work_r  <= '0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ch_r    <= '0;
                    work_r  <= '0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel0_o  = ch_r[0];
    assign sel1_o  = ch_r[1];
    assign busy_o  = busy_r;
    assign data_o  = data_r;
    assign valid_o = valid_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed + randomized bench for mux_scan_ctrl with SETTLE_CYCLES=2 and =1;
// the mux is modelled as a zero-delay 4:1 selection of a pattern word.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cont, ready, use_b;
    logic [3:0] pat;

    logic       start_a, ready_a, mux_a, sel0_a, sel1_a, busy_a, valid_a;
    logic       start_b, ready_b, mux_b, sel0_b, sel1_b, busy_b, valid_b;
    logic [3:0] data_a, data_b;

    logic [1:0] v_sel;
    logic       v_busy, v_valid;
    logic [3:0] v_data;
    int         sc;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~use_b;
    assign start_b = start & use_b;
    assign ready_a = ready & ~use_b;
    assign ready_b = ready & use_b;
    assign mux_a   = pat[{sel1_a, sel0_a}];
    assign mux_b   = pat[{sel1_b, sel0_b}];

    assign v_sel   = use_b ? {sel1_b, sel0_b} : {sel1_a, sel0_a};
    assign v_busy  = use_b ? busy_b  : busy_a;
    assign v_valid = use_b ? valid_b : valid_a;
    assign v_data  = use_b ? data_b  : data_a;

    mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .cont_i(cont),
        .mux_out_i(mux_a), .sel0_o(sel0_a), .sel1_o(sel1_a), .busy_o(busy_a),
        .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .cont_i(cont),
        .mux_out_i(mux_b), .sel0_o(sel0_b), .sel1_o(sel1_b), .busy_o(busy_b),
        .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] exp_data);
        check({tag, "_sel"},   8'(v_sel),   8'd0);
        check({tag, "_busy"},  8'(v_busy),  8'd0);
        check({tag, "_valid"}, 8'(v_valid), 8'd0);
        check({tag, "_data"},  8'(v_data),  8'(exp_data));
    endtask

    // From IDLE: start a scan of pattern p; ends on the first cycle valid is high.
    // Expected select at cycle k after acceptance is k/sc; the word equals p.
    task automatic do_scan(input logic [3:0] p, input string tag);
        pat   = p;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4 * sc; k++) begin
            check({tag, "_sel"},   8'(v_sel),   8'(k / sc));
            check({tag, "_busy"},  8'(v_busy),  8'd1);
            check({tag, "_valid"}, 8'(v_valid), 8'd0);
            step();
        end
        check({tag, "_done_valid"}, 8'(v_valid), 8'd1);
        check({tag, "_done_data"},  8'(v_data),  8'(p));
        check({tag, "_done_sel"},   8'(v_sel),   8'd3);
        check({tag, "_done_busy"},  8'(v_busy),  8'd1);
    endtask

    task automatic handshake_stop(input logic [3:0] p, input string tag);
        cont  = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_idle(tag, p);
    endtask

    initial begin
        logic [3:0] p;
        int         n;
        int         bp;

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b0;
        use_b = 1'b0; pat = 4'b0000; sc = 2;
        step(); step();
        check_idle("rst_a", 4'b0000);
        use_b = 1'b1;
        #0 check_idle("rst_b", 4'b0000);
        use_b = 1'b0;
        rst_n = 1'b1;
        step();
        check_idle("idle_a", 4'b0000);

        // Single scan with backpressure in DONE
        do_scan(4'b1101, "single");
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 8'(v_valid), 8'd1);
            check("bp_data",  8'(v_data),  8'h0d);
            check("bp_sel",   8'(v_sel),   8'd3);
        end
        handshake_stop(4'b1101, "bp_release");

        // Continuous mode: words 9 cycles apart, no leakage of old bits
        cont  = 1'b1;
        ready = 1'b1;
        do_scan(4'b0110, "cont1");
        pat = 4'b1001;
        step();
        check("cont_gap_valid", 8'(v_valid), 8'd0);
        check("cont_gap_busy",  8'(v_busy),  8'd1);
        check("cont_gap_sel",   8'(v_sel),   8'd0);
        cont = 1'b0;
        n = 1;
        while (!v_valid && n < 20) begin
            step();
            n++;
        end
        check("cont_period", 8'(n), 8'd9);
        check("cont2_data",  8'(v_data), 8'h09);
        step();
        ready = 1'b0;
        check_idle("cont_stop", 4'b1001);

        // Randomized scans with random backpressure
        for (int r = 0; r < 6; r++) begin
            p  = 4'($urandom_range(0, 15));
            bp = $urandom_range(0, 3);
            do_scan(p, "rand_a");
            for (int i = 0; i < bp; i++) begin
                step();
                check("rand_a_hold", 8'(v_data), 8'(p));
            end
            handshake_stop(p, "rand_a_end");
        end

        // start ignored during SETTLE and DONE, no queuing
        p = 4'($urandom_range(0, 15));
        pat = p;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ign_sel",   8'(v_sel),   8'(k / 2));
            check("ign_valid", 8'(v_valid), 8'd0);
            start = (k == 2);
            step();
        end
        start = 1'b0;
        check("ign_done_valid", 8'(v_valid), 8'd1);
        check("ign_done_data",  8'(v_data),  8'(p));
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_done_hold", 8'(v_valid), 8'd1);
        check("ign_done_sel",  8'(v_sel),   8'd3);
        handshake_stop(p, "ign_end");
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n += int'(v_valid) + int'(v_busy);
        end
        check("ign_no_restart", 8'(n), 8'd0);

        // SETTLE_CYCLES=1 instance
        use_b = 1'b1;
        sc    = 1;
        #0 check_idle("b_idle", 4'b0000);
        do_scan(4'b1010, "b_1010");
        handshake_stop(4'b1010, "b_1010_end");
        for (int r = 0; r < 4; r++) begin
            p = 4'($urandom_range(0, 15));
            do_scan(p, "rand_b");
            handshake_stop(p, "rand_b_end");
        end
        use_b = 1'b0;
        sc    = 2;

        // Reset during ch=2 drops the partial word
        pat   = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("mid_sel_before", 8'(v_sel), 8'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("mid_rst", 4'b0000);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n += int'(v_valid);
        end
        check("mid_no_valid", 8'(n), 8'd0);
        check_idle("mid_after", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
